seg_to_code_dec: RTL and testbench
==================================

// Module: seg_to_code_dec
// PURPOSE
//  Decoder for the 7-segment test-pattern bus driven by the code-to-segment encoder.
//  Samples seg_in and filters glitches with a stability counter.
//  Maps each accepted pattern back to a symbol class and hands it downstream over valid/ready.
//  Reports only changes of pattern. Sits on the capture side of the test link.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical samples needed to accept a pattern (>=1)
//  CNT_W          8  width of error counter (SEG_DEC_ERRCNT_EN only)
// PORTS
//  clk        in   1      single system clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  seg_in     in   7      segment pattern, bit6..bit0 in encoder order
//  out_ready  in   1      downstream can take a symbol
//  out_valid  out  1      symbol held on out_class/out_err
//  out_class  out  2      decoded class (table below)
//  out_err    out  1      accepted pattern not in table
//  busy       out  1      FSM not in IDLE
//  err_cnt    out  CNT_W  accepted-error count (only with SEG_DEC_ERRCNT_EN)
// BEHAVIOUR
//  Decode table (seg_in -> out_class, out_err=0):
//   7'b0001111 -> 2'd0 (codes 0/3)
//   7'b1011011 -> 2'd1
//   7'b1001111 -> 2'd2
//   7'b0000001 -> 2'd3 (codes 4..7)
//   Any other pattern -> out_class=2'd0, out_err=1.
//  Reset (async, immediate): out_valid=0, out_class=0, out_err=0, busy=0, err_cnt=0, FSM=IDLE.
//   Also clears seg_q, stab_cnt, last, last_vld.
//  seg_q: seg_in registered every cycle. last/last_vld: most recently reported pattern.
//  FSM IDLE: if !last_vld or seg_q!=last -> SETTLE with stab_cnt=1.
//  FSM SETTLE: stab_cnt counts clocks where seg_in==seg_q.
//   On any mismatch: reset stab_cnt to 1 and stay in SETTLE.
//   If seg_q==last && last_vld -> IDLE (glitch returned to old value, nothing reported).
//   When stab_cnt reaches STABLE_CYCLES: latch decode of seg_q into out_class/out_err.
//   In the same cycle set last=seg_q, last_vld=1 and go to VALID.
//  FSM VALID: out_valid=1. out_class/out_err held constant regardless of seg_in.
//   Transfer when out_valid && out_ready; next cycle out_valid=0 and FSM=IDLE.
//   out_ready with out_valid=0 is ignored.
//  Latency: seg_in changes before edge 0 and is held -> out_valid=1 after edge STABLE_CYCLES+1.
//  Input changes during VALID are not lost. IDLE compares against last after the transfer.
//   The final stable pattern is therefore reported. Intermediate patterns are dropped.
//  busy = (FSM != IDLE).
//  stab_cnt width = clog2(STABLE_CYCLES+1); it saturates and never wraps.
//  First stable pattern after reset is always reported, including 7'b0000001.
// CONFIGURATION
//  SEG_DEC_ERRCNT_EN defined:
//   err_cnt port exists.
//   Increments by 1 on each transfer with out_err=1.
//   Saturates at 2**CNT_W-1. Cleared only by rst_n.
//  SEG_DEC_ERRCNT_EN undefined: no err_cnt port and no counter logic. All other behaviour is identical.
// TESTING
//  STABLE_CYCLES=4; reset, then hold seg_in=7'b1011011, out_ready=1:
//   out_valid=1 for exactly one cycle after edge 5, with out_class=1, out_err=0. No repeat while held.
//  1-cycle glitch 7'b1001111 inside steady 7'b1011011 -> no out_valid. busy pulses then returns to 0.
//  seg_in=7'b0000001, out_ready=0 for 20 cycles:
//   out_valid stays 1 with out_class=3.
//   Change seg_in to 7'b0001111 at cycle 10 -> out_class stays 3.
//   Raise ready -> class 3 transfers, then out_class=0 is reported.
//  seg_in=7'b1111111 stable -> out_class=0, out_err=1.
//   With SEG_DEC_ERRCNT_EN: after transfer err_cnt=1; with CNT_W=2 after 5 errors err_cnt=3.
//  Assert rst_n=0 while out_valid=1:
//   out_valid drops with no clock edge.
//   After release, same stable seg_in is re-reported after STABLE_CYCLES+1 edges.
//  Sweep all four table patterns back-to-back, each held 8 cycles, out_ready=1 -> classes 0,1,2,3 in order.

Source files
------------

// File: rtl/seg_to_code_dec.sv
// seg_to_code_dec: glitch-filtered 7-segment pattern decoder with valid/ready output.
// Optional SEG_DEC_ERRCNT_EN adds a saturating err_cnt of transferred error symbols.
module seg_to_code_dec #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [1:0]       out_class,
  output logic             out_err,
`ifdef SEG_DEC_ERRCNT_EN
  output logic [CNT_W-1:0] err_cnt,
`endif
  output logic             busy
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, VALID} state_t;
  state_t        state_q, state_d;
  logic [6:0]    seg_q, last_q, last_d;
  logic          last_vld_q, last_vld_d;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic [1:0]    out_class_q, out_class_d, dec_class;
  logic          out_err_q, out_err_d, dec_err;
  assign dec_class = seg_q == 7'b1011011 ? 2'd1 :
                     seg_q == 7'b1001111 ? 2'd2 :
                     seg_q == 7'b0000001 ? 2'd3 : 2'd0;
  assign dec_err   = !(seg_q == 7'b0001111 || seg_q == 7'b1011011 ||
                       seg_q == 7'b1001111 || seg_q == 7'b0000001);
  assign out_valid = state_q == VALID;
  assign busy      = state_q != IDLE;
  assign out_class = out_class_q;
  assign out_err   = out_err_q;
  always_comb begin
    state_d     = state_q;
    stab_cnt_d  = stab_cnt_q;
    last_d      = last_q;
    last_vld_d  = last_vld_q;
    out_class_d = out_class_q;
    out_err_d   = out_err_q;
    case (state_q)
      IDLE: if (!last_vld_q || seg_q != last_q) begin
        state_d    = SETTLE;
        stab_cnt_d = SW'(1);
      end
      SETTLE: if (seg_in != seg_q) stab_cnt_d = SW'(1);
      else if (last_vld_q && seg_q == last_q) state_d = IDLE;
      else if (stab_cnt_q >= SW'(STABLE_CYCLES)) begin
        state_d     = VALID;
        out_class_d = dec_class;
        out_err_d   = dec_err;
        last_d      = seg_q;
        last_vld_d  = 1'b1;
      end else stab_cnt_d = stab_cnt_q + SW'(1);
      VALID: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      seg_q       <= '0;
      stab_cnt_q  <= '0;
      last_q      <= '0;
      last_vld_q  <= 1'b0;
      out_class_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_in;
      stab_cnt_q  <= stab_cnt_d;
      last_q      <= last_d;
      last_vld_q  <= last_vld_d;
      out_class_q <= out_class_d;
      out_err_q   <= out_err_d;
    end
  end
`ifdef SEG_DEC_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  assign err_cnt   = err_cnt_q;
  assign err_cnt_d = (out_valid && out_ready && out_err_q && err_cnt_q != '1) ?
                     err_cnt_q + CNT_W'(1) : err_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end
`endif
endmodule

// File: tb/tb_seg_to_code_dec.sv
// tb_seg_to_code_dec: table vectors, corner sequences and random runs vs a run-level model.
module tb_seg_to_code_dec;
  localparam int SC = 4;
  localparam int CW = 8;
  logic       clk = 1'b0, rst_n = 1'b1, out_ready = 1'b0;
  logic [6:0] seg_in = 7'b1011011;
  logic       out_valid, out_err, busy;
  logic [1:0] out_class;
`ifdef SEG_DEC_ERRCNT_EN
  logic [CW-1:0] err_cnt;
`endif
  seg_to_code_dec #(.STABLE_CYCLES(SC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_class(out_class), .out_err(out_err),
`ifdef SEG_DEC_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .busy(busy));
  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0, err_model = 0;
  logic [2:0] got[$];
  typedef struct { logic [6:0] seg; logic [1:0] cls; logic err; } vec_t;
  vec_t tbl[7];
  logic [6:0] pats[6];

  // transfers seen on the bus, and the error count they imply
  always @(negedge clk) begin
    if (!rst_n) err_model = 0;
    else if (out_valid && out_ready) begin
      got.push_back({out_err, out_class});
      if (out_err && err_model < (1 << CW) - 1) err_model++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      tick;
      n++;
    end
    chk("wait_valid", 32'(out_valid), 1);
  endtask

  task automatic chk_errcnt;
`ifdef SEG_DEC_ERRCNT_EN
    chk("err_cnt", 32'(err_cnt), err_model);
`endif
  endtask

  function automatic logic [2:0] ref_dec(input logic [6:0] p);
    logic [6:0] k[4];
    k = '{7'b0001111, 7'b1011011, 7'b1001111, 7'b0000001};
    for (int i = 0; i < 4; i++) if (p == k[i]) return {1'b0, 2'(i)};
    return 3'b100;
  endfunction

  initial begin
    int cnt, hits, len, idx, prev;
    logic seen_b, seen_v, have;
    logic [1:0] c;
    logic e;
    logic [6:0] last;
    logic [2:0] exp_q[$];
    tbl[0] = '{7'b0001111, 2'd0, 1'b0};
    tbl[1] = '{7'b1011011, 2'd1, 1'b0};
    tbl[2] = '{7'b1001111, 2'd2, 1'b0};
    tbl[3] = '{7'b0000001, 2'd3, 1'b0};
    tbl[4] = '{7'b1111111, 2'd0, 1'b1};
    tbl[5] = '{7'b0000000, 2'd0, 1'b1};
    tbl[6] = '{7'b0001111, 2'd0, 1'b0};
    pats = '{7'b0001111, 7'b1011011, 7'b1001111, 7'b0000001, 7'b1111111, 7'b0110110};

    out_ready = 1'b1;
    rst_n = 1'b0;
    tick;
    tick;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_class", 32'(out_class), 0);
    chk("rst_err", 32'(out_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk_errcnt;
    rst_n = 1'b1;
    for (int k = 1; k <= SC; k++) begin
      tick;
      chk("lat_early", 32'(out_valid), 0);
    end
    tick;
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_class", 32'(out_class), 1);
    chk("lat_err", 32'(out_err), 0);
    tick;
    chk("lat_drop", 32'(out_valid), 0);
    cnt = 0;
    repeat (10) begin
      tick;
      cnt += 32'(out_valid);
    end
    chk("no_repeat", cnt, 0);

    seg_in = 7'b1001111;
    tick;
    seg_in = 7'b1011011;
    seen_b = 0;
    seen_v = 0;
    repeat (12) begin
      tick;
      seen_b |= busy;
      seen_v |= out_valid;
    end
    chk("glitch_busy", 32'(seen_b), 1);
    chk("glitch_valid", 32'(seen_v), 0);
    chk("glitch_idle", 32'(busy), 0);

    out_ready = 1'b0;
    seg_in = 7'b0000001;
    wait_valid(20);
    hits = 0;
    repeat (10) begin
      tick;
      if (out_valid && out_class == 2'd3) hits++;
    end
    seg_in = 7'b0001111;
    repeat (10) begin
      tick;
      if (out_valid && out_class == 2'd3) hits++;
    end
    chk("hold_class3", hits, 20);
    out_ready = 1'b1;
    tick;
    chk("hold_xfer", 32'(out_valid), 0);
    chk("hold_xfer_got", 32'(got[$]), 3'b011);
    wait_valid(20);
    chk("hold_next_class", 32'(out_class), 0);
    chk("hold_next_err", 32'(out_err), 0);
    tick;

    seg_in = 7'b1111111;
    wait_valid(20);
    chk("bad_class", 32'(out_class), 0);
    chk("bad_err", 32'(out_err), 1);
    tick;
    chk_errcnt;

    out_ready = 1'b0;
    seg_in = 7'b1001111;
    wait_valid(20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_class", 32'(out_class), 0);
    chk("async_err", 32'(out_err), 0);
    tick;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= SC; k++) begin
      tick;
      chk("rerep_early", 32'(out_valid), 0);
    end
    tick;
    chk("rerep_valid", 32'(out_valid), 1);
    chk("rerep_class", 32'(out_class), 2);
    tick;

    for (int i = 0; i < 7; i++) begin
      seg_in = tbl[i].seg;
      hits = 0;
      c = 0;
      e = 0;
      repeat (8) begin
        tick;
        if (out_valid && out_ready) begin
          hits++;
          c = out_class;
          e = out_err;
        end
      end
      chk("tbl_hits", hits, 1);
      chk("tbl_class", 32'(c), 32'(tbl[i].cls));
      chk("tbl_err", 32'(e), 32'(tbl[i].err));
    end
    chk_errcnt;

    // random runs: long runs (>=8) of a new pattern are reported once, short ones never
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    got.delete();
    have = 0;
    last = '0;
    prev = -1;
    for (int r = 0; r < 40; r++) begin
      do idx = $urandom_range(5); while (idx == prev);
      prev = idx;
      len = (r == 0 || r == 39 || $urandom_range(2) != 0) ? $urandom_range(12, 8) : $urandom_range(2, 1);
      seg_in = pats[idx];
      repeat (len) tick;
      if (len >= 8 && (!have || pats[idx] != last)) begin
        exp_q.push_back(ref_dec(pats[idx]));
        last = pats[idx];
        have = 1;
      end
    end
    repeat (4) tick;
    chk("rand_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk("rand_sym", 32'(got[i]), 32'(exp_q[i]));
    chk_errcnt;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
